// File: rtl/bg_model_ema_if.sv
// Pixel stream, detection result and SRAM control bundle for bg_model_ema.
// The SRAM data bus stays a plain inout on the module, so tristate resolution remains at module level.
interface bg_model_ema_if #(
    parameter int PIX_W  = 10,
    parameter int ADDR_W = 20
);
    logic              i_valid;
    logic              o_ready;
    logic              i_sof;
    logic              i_freeze;
    logic [PIX_W-1:0]  i_r;
    logic [PIX_W-1:0]  i_g;
    logic [PIX_W-1:0]  i_b;
    logic              o_fg_valid;
    logic              o_fg;
    logic [7:0]        o_gray;
    logic              o_learning;
    logic              o_sram_rd;
    logic              o_sram_wr;
    logic [ADDR_W-1:0] o_sram_addr;

    modport master (
        output i_valid, i_sof, i_freeze, i_r, i_g, i_b,
        input  o_ready, o_fg_valid, o_fg, o_gray, o_learning,
        input  o_sram_rd, o_sram_wr, o_sram_addr
    );

    modport slave (
        input  i_valid, i_sof, i_freeze, i_r, i_g, i_b,
        output o_ready, o_fg_valid, o_fg, o_gray, o_learning,
        output o_sram_rd, o_sram_wr, o_sram_addr
    );
endinterface

// File: rtl/bg_model_ema.sv
// Per-pixel EMA background model (mean/variance held in external async SRAM) with a
// one-bit foreground detector; each accepted pixel costs one read pair and, unless frozen, one write pair.
module bg_model_ema #(
    parameter int H_ACT        = 640,
    parameter int V_ACT        = 480,
    parameter int PIX_W        = 10,
    parameter int ADDR_W       = 20,
    parameter int BASE_ADDR    = 0,
    parameter int ALPHA_SHIFT  = 5,
    parameter int K_THRESH     = 9,
    parameter int LEARN_FRAMES = 32,
    parameter int INIT_VAR     = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    bg_model_ema_if.slave    bus,
    inout  wire  [15:0]      io_sram_dq
);
    localparam int NPIX  = H_ACT * V_ACT;
    localparam int POS_W = $clog2(NPIX) + 1;
    localparam int SUM_W = PIX_W + 7;
    localparam logic [7:0]        LEARN_N  = 8'(LEARN_FRAMES);
    localparam logic [15:0]       VAR_INIT = 16'(INIT_VAR);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {IDLE, RD0, RD1, CALC, WR0, WR1} state_t;

    state_t            r_state;
    logic [POS_W-1:0]  r_pos;
    logic [7:0]        r_frameCnt;
    logic [7:0]        r_gray;
    logic              r_freeze;
    logic [11:0]       r_mean;
    logic [15:0]       r_var;
    logic [15:0]       r_varNext;
    logic [15:0]       r_dqOut;
    logic [ADDR_W-1:0] r_pixAddr;
    logic [ADDR_W-1:0] r_sramAddr;
    logic              r_sramRd;
    logic              r_sramWr;
    logic              r_fgValid;
    logic              r_fg;
    logic [7:0]        r_grayOut;

    logic [SUM_W-1:0]   w_graySum;
    logic [7:0]         w_gray;
    logic [POS_W-1:0]   w_posAcc;
    logic [ADDR_W-1:0]  w_acceptAddr;
    logic               w_firstFrame;
    logic               w_learning;
    logic               w_lastPix;
    logic               w_advance;
    logic signed [12:0] w_diff;
    logic signed [12:0] w_diffSh;
    logic signed [8:0]  w_d;
    logic signed [17:0] w_dExt;
    logic [15:0]        w_d2;
    logic [11:0]        w_meanUpd;
    logic signed [17:0] w_varDelta;
    logic signed [17:0] w_varSum;
    logic [15:0]        w_varUpd;
    logic [23:0]        w_thresh;
    logic               w_fgRaw;
    logic [11:0]        w_meanNext;
    logic [15:0]        w_varNextC;

    assign w_graySum = SUM_W'(38) * SUM_W'(bus.i_r) + SUM_W'(75) * SUM_W'(bus.i_g)
                     + SUM_W'(15) * SUM_W'(bus.i_b);
    assign w_gray    = 8'(w_graySum >> (PIX_W - 1));

    assign w_posAcc     = bus.i_sof ? '0 : r_pos;
    assign w_acceptAddr = BASE + (ADDR_W'(w_posAcc) << 1);
    assign w_firstFrame = (r_frameCnt == 8'd0);
    assign w_learning   = (r_frameCnt < LEARN_N);
    assign w_lastPix    = (r_pos == POS_W'(NPIX - 1));
    assign w_advance    = ((r_state == CALC) && r_freeze) || (r_state == WR1);

    // Mean is Q8.4, so d is the integer part of the gray-to-mean distance.
    assign w_diff     = $signed({1'b0, r_gray, 4'b0000}) - $signed({1'b0, r_mean});
    assign w_diffSh   = w_diff >>> ALPHA_SHIFT;
    assign w_d        = w_diff[12:4];
    assign w_dExt     = {{9{w_d[8]}}, w_d};
    assign w_d2       = 16'(w_dExt * w_dExt);
    assign w_meanUpd  = r_mean + 12'(w_diffSh);
    assign w_varDelta = $signed({2'b00, w_d2}) - $signed({2'b00, r_var});
    assign w_varSum   = $signed({2'b00, r_var}) + (w_varDelta >>> ALPHA_SHIFT);
    assign w_thresh   = 24'(K_THRESH) * {8'd0, r_var};
    assign w_fgRaw    = ({8'd0, w_d2} > w_thresh);

    // A zero variance would make every later pixel foreground, so the update floors at 1.
    always_comb begin
        w_varUpd = w_varSum[15:0];
        if (w_varSum < 18'sd1) begin
            w_varUpd = 16'd1;
        end else if (w_varSum > 18'sd65535) begin
            w_varUpd = 16'hFFFF;
        end
        w_meanNext = w_firstFrame ? {r_gray, 4'b0000} : w_meanUpd;
        w_varNextC = w_firstFrame ? VAR_INIT : w_varUpd;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_gray     <= '0;
            r_freeze   <= 1'b0;
            r_mean     <= '0;
            r_var      <= '0;
            r_varNext  <= '0;
            r_dqOut    <= '0;
            r_pixAddr  <= BASE;
            r_sramAddr <= BASE;
            r_sramRd   <= 1'b0;
            r_sramWr   <= 1'b0;
            r_fgValid  <= 1'b0;
            r_fg       <= 1'b0;
            r_grayOut  <= '0;
        end else begin
            r_fgValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_valid) begin
                        r_gray     <= w_gray;
                        r_freeze   <= bus.i_freeze;
                        r_pixAddr  <= w_acceptAddr;
                        r_sramAddr <= w_acceptAddr;
                        r_sramRd   <= 1'b1;
                        r_state    <= RD0;
                    end
                end
                RD0: begin
                    r_mean     <= io_sram_dq[11:0];
                    r_sramAddr <= r_pixAddr + ADDR_W'(1);
                    r_state    <= RD1;
                end
                RD1: begin
                    r_var    <= io_sram_dq;
                    r_sramRd <= 1'b0;
                    r_state  <= CALC;
                end
                CALC: begin
                    r_fgValid <= 1'b1;
                    r_fg      <= w_fgRaw && !w_learning && !w_firstFrame;
                    r_grayOut <= r_gray;
                    r_varNext <= w_varNextC;
                    if (!r_freeze) begin
                        r_sramWr   <= 1'b1;
                        r_sramAddr <= r_pixAddr;
                        r_dqOut    <= {4'b0000, w_meanNext};
                        r_state    <= WR0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WR0: begin
                    r_sramAddr <= r_pixAddr + ADDR_W'(1);
                    r_dqOut    <= r_varNext;
                    r_state    <= WR1;
                end
                WR1: begin
                    r_sramWr <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A natural wrap bumps the frame count; a later i_sof only re-zeroes the position.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pos      <= '0;
            r_frameCnt <= '0;
        end else if ((r_state == IDLE) && bus.i_valid && bus.i_sof) begin
            r_pos <= '0;
        end else if (w_advance) begin
            r_pos <= w_lastPix ? '0 : r_pos + POS_W'(1);
            if (w_lastPix && (r_frameCnt < LEARN_N)) begin
                r_frameCnt <= r_frameCnt + 8'd1;
            end
        end
    end

    assign io_sram_dq      = r_sramWr ? r_dqOut : 16'bz;
    assign bus.o_ready     = (r_state == IDLE);
    assign bus.o_fg_valid  = r_fgValid;
    assign bus.o_fg        = r_fg;
    assign bus.o_gray      = r_grayOut;
    assign bus.o_learning  = w_learning;
    assign bus.o_sram_rd   = r_sramRd;
    assign bus.o_sram_wr   = r_sramWr;
    assign bus.o_sram_addr = r_sramAddr;
endmodule

// File: doc/bg_model_ema.md
# bg_model_ema

Parametrised per-pixel background model and foreground detector for the camera pipeline. For each accepted RGB pixel it:
- converts the pixel to 8-bit gray;
- read-modify-writes an exponential-moving-average mean/variance pair held in external 16-bit SRAM;
- emits a one-bit foreground flag.

It sits between the camera capture stream and the VGA/overlay path, and owns its own SRAM window.

## Interface
Parameters:
- H_ACT, 640, active pixels per line
- V_ACT, 480, active lines per frame
- PIX_W, 10, width of each input colour channel
- ADDR_W, 20, SRAM address width
- BASE_ADDR, 0, first SRAM word of the model window
- ALPHA_SHIFT, 5, EMA rate; alpha = 2^-ALPHA_SHIFT (1..8)
- K_THRESH, 9, foreground threshold on d²/var (integer, 1..255)
- LEARN_FRAMES, 32, frames after reset with o_fg forced 0 (1..255)
- INIT_VAR, 64, variance loaded on the first frame

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  pixel available
- o_ready  out  1  block can accept a pixel this cycle
- i_sof  in  1  qualifies the accepted pixel as first of frame
- i_freeze  in  1  detect without updating the model
- i_r, i_g, i_b  in  PIX_W  colour channels
- o_fg_valid  out  1  one-cycle strobe, o_fg/o_gray valid
- o_fg  out  1  foreground flag
- o_gray  out  8  gray value of the pixel
- o_learning  out  1  model still in learning period
- o_sram_rd  out  1  SRAM read strobe
- o_sram_wr  out  1  SRAM write strobe
- o_sram_addr  out  ADDR_W  SRAM word address
- io_sram_dq  inout  16  SRAM data; driven only while o_sram_wr=1, else high-Z

## Operation
FSM states and transitions:
- IDLE→RD0 when i_valid&o_ready.
- RD0→RD1→CALC.
- CALC→WR0 if !i_freeze (sampled at acceptance), else CALC→IDLE.
- WR0→WR1→IDLE.
- o_ready = (state==IDLE).

On accept:
- Latch gray = (38·R + 75·G + 15·B) >> (PIX_W-1), truncated to 8 bits.
- If i_sof=1, the position counter is reset to 0 for this pixel.

Pixel n occupies two SRAM words:
- Word 0 at BASE_ADDR+2n: mean, Q8.4 unsigned, in bits [11:0]; bits [15:12] are written 0.
- Word 1 at BASE_ADDR+2n+1: var, 16-bit unsigned.
- The address counter steps by 2 per pixel. After pixel H_ACT·V_ACT-1 it wraps to BASE_ADDR, and frame_cnt increments, saturating at LEARN_FRAMES.

RD0 and RD1 assert o_sram_rd with the word 0 and word 1 addresses respectively. The data is sampled at the end of the cycle (asynchronous SRAM).

CALC arithmetic, with first_frame = (frame_cnt==0):
- diff = (gray<<4) − mean, 13-bit signed.
- d = diff>>>4; d2 = d·d, 16-bit.
- mean' = mean + (diff>>>ALPHA_SHIFT).
- var' = var + ((d2 − var)>>>ALPHA_SHIFT), evaluated at 18-bit signed and clamped to [1, 65535].
- If first_frame: mean' = gray<<4, var' = INIT_VAR, and the read data is ignored.
- fg = (d2 > K_THRESH·var), using the pre-update var at full width.
- fg is forced to 0 while o_learning or first_frame.

Outputs from CALC:
- o_fg, o_gray and o_fg_valid are registered at the end of CALC, so o_fg_valid is high for the cycle after CALC.
- WR0 writes mean' and WR1 writes var', each with o_sram_wr=1 and io_sram_dq driven.

o_learning = (frame_cnt < LEARN_FRAMES).

Freeze:
- i_freeze=1 at acceptance skips WR0/WR1. The model and SRAM are unchanged, but the position still advances.

## Timing
Reset values:
- state=IDLE; o_ready=1.
- o_fg_valid=0, o_fg=0, o_gray=0.
- o_sram_rd=0, o_sram_wr=0, o_sram_addr=BASE_ADDR, io_sram_dq high-Z.
- frame_cnt=0, so o_learning=1.

Latency and throughput:
- Acceptance edge → o_fg_valid is 3 cycles (RD0, RD1, CALC), high in the 4th.
- Throughput is 1 pixel per 6 cycles, or per 4 cycles under freeze.

Boundary behaviour:
- i_valid while o_ready=0 is ignored; the source holds the pixel.
- Reset mid-operation releases io_sram_dq immediately (asynchronously). A partially written pair is overwritten on the next pass.
- i_sof mid-frame resets the position but not frame_cnt.
- A natural wrap and i_sof on the first pixel of the next frame together give exactly one frame_cnt increment.
- Strobes are single-cycle and never overlap: rd and wr are never both 1.

## Test plan
Bench uses H_ACT=4, V_ACT=2, LEARN_FRAMES=2, ALPHA_SHIFT=2, K_THRESH=4, INIT_VAR=64, PIX_W=10.
- Gray conversion: R=G=B=1023 → o_gray=255; R=1023, G=B=0 → o_gray=75.
- First frame, gray=100 at pixel 0 → word0 (addr 0) = 0x0640, word1 (addr 1) = 64, o_fg=0; 8 pixels → addresses 0..15, then wrap to 0.
- Steady state mean=100, var=64, frames≥2, gray=120: d=20, d2=400 > 256 → o_fg=1, mean'=0x0690 (105), var'=148; gray=108: d2=64 ≤ 256 → o_fg=0.
- Same stimulus during frame 1 (o_learning=1) → o_fg=0, SRAM still updated.
- i_freeze=1 with gray=120 → o_fg=1, no o_sram_wr pulse, next pixel accepted 4 cycles later.
- Reset asserted during WR0 → io_sram_dq high-Z and o_sram_wr=0 within the reset cycle, o_ready=1, frame_cnt=0; i_valid held low 10 cycles → no strobes.
